// File: rtl/inst_encoder_if.sv
// Request/beat bundle for inst_encoder: decoded fields in, packed RV32I words out.
// The slave modport is the encoder side; the master modport is the producer/consumer side.
interface inst_encoder_if #(
    parameter int unsigned COUNT_W = 16
) ();
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_sel;
    logic [6:0]         in_opcode;
    logic [4:0]         in_rd;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic [2:0]         in_funct3;
    logic [6:0]         in_funct7;
    logic [31:0]        in_imm;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_inst;
    logic               out_err;
    logic               out_last;
    logic [COUNT_W-1:0] beat_count;

    modport slave (
        input  in_valid, in_sel, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
        input  in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err, out_last, beat_count
    );

    modport master (
        output in_valid, in_sel, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
        output in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err, out_last, beat_count
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words, range-checks
// immediates and expands the li pseudo-instruction into ADDI or LUI+ADDI beats.
module inst_encoder #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    inst_encoder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StHold, StLiHi} state_e;

    localparam logic [6:0] OpOpImm = 7'b0010011;
    localparam logic [6:0] OpLui   = 7'b0110111;

    state_e             state_q, state_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        pend_q, pend_d;
    logic               err_q, err_d;
    logic               last_q, last_d;
    logic [COUNT_W-1:0] beat_count_q, beat_count_d;

    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign imm = bus.in_imm;
    assign op  = bus.in_opcode;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    assign f3  = bus.in_funct3;
    assign f7  = bus.in_funct7;

    // Sign-extension checks: upper bits must all match the top kept bit.
    logic        fits12, fits13, fits21;
    logic [19:0] li_hi;

    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);
    // Round up so the sign-extended ADDI low part lands on the requested value.
    assign li_hi  = imm[31:12] + {19'd0, imm[11]};

    logic [31:0] enc_inst;
    logic [31:0] enc_pend;
    logic        enc_err;
    logic        enc_two;

    always_comb begin
        enc_inst = '0;
        enc_pend = '0;
        enc_err  = 1'b0;
        enc_two  = 1'b0;
        unique case (bus.in_sel)
            3'b000: begin
                enc_inst = {imm[11:0], rs1, f3, rd, op};
                enc_err  = ~fits12;
            end
            3'b001: begin
                enc_inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                enc_err  = ~fits12;
            end
            3'b010: begin
                enc_inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                enc_err  = ~fits13 | imm[0];
            end
            3'b011: begin
                enc_inst = {imm[31:12], rd, op};
                enc_err  = |imm[11:0];
            end
            3'b100: begin
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                enc_err  = ~fits21 | imm[0];
            end
            3'b101: begin
                if (fits12) begin
                    enc_inst = {imm[11:0], 5'd0, 3'b000, rd, OpOpImm};
                end else begin
                    enc_inst = {li_hi, rd, OpLui};
                    enc_pend = {imm[11:0], rd, 3'b000, rd, OpOpImm};
                    enc_two  = 1'b1;
                end
            end
            3'b110: begin
                enc_inst = {f7, rs2, rs1, f3, rd, op};
            end
            3'b111: begin
                enc_inst = 32'hDEADBEEF;
                enc_err  = 1'b1;
            end
        endcase
    end

    logic in_ready;
    logic out_valid;
    logic accept;
    logic consume;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            StIdle:  in_ready = 1'b1;
            StHold:  in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid = (state_q != StIdle);
    assign accept    = bus.in_valid & in_ready;
    assign consume   = out_valid & bus.out_ready;

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        pend_d       = pend_q;
        err_d        = err_q;
        last_d       = last_q;
        beat_count_d = beat_count_q + COUNT_W'(consume);
        case (state_q)
            StIdle, StHold: begin
                if (consume) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    state_d = enc_two ? StLiHi : StHold;
                    inst_d  = enc_inst;
                    pend_d  = enc_pend;
                    err_d   = enc_err;
                    last_d  = ~enc_two;
                end
            end
            StLiHi: begin
                if (consume) begin
                    state_d = StHold;
                    inst_d  = pend_q;
                    err_d   = 1'b0;
                    last_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            inst_q       <= '0;
            pend_q       <= '0;
            err_q        <= 1'b0;
            last_q       <= 1'b0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
            last_q       <= last_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_inst   = inst_q;
    assign bus.out_err    = err_q;
    assign bus.out_last   = last_q;
    assign bus.beat_count = beat_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: fixed vectors, hand-built multi-cycle sequences and random
// traffic scored against an arithmetic reference model of the encodings.
module tb_inst_encoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_encoder_if #(.COUNT_W(16)) bus ();

    inst_encoder #(.COUNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]  sel;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic        last;
    } beat_t;

    typedef struct {
        req_t        r;
        logic [31:0] inst;
        logic        err;
        logic        last;
    } vec_t;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned nbeats = 0;
    beat_t       exp_q[$];
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic req_t mk(input int sel, input int op, input int rd, input int rs1,
                                input int rs2, input int f3, input int f7, input int imm);
        req_t r;
        r.sel = 3'(sel); r.op = 7'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
        r.f3 = 3'(f3); r.f7 = 7'(f7); r.imm = 32'(imm);
        return r;
    endfunction

    // Reference: field placement by shift/mask, ranges by signed comparison.
    task automatic model(input req_t r);
        int signed   s;
        logic [31:0] u, rd, rs1, rs2, f3, f7, op, w, hi;
        logic        e;
        s = r.imm; u = r.imm;
        rd = 32'(r.rd); rs1 = 32'(r.rs1); rs2 = 32'(r.rs2);
        f3 = 32'(r.f3); f7 = 32'(r.f7); op = 32'(r.op);
        w = 0; e = 1'b0;
        case (r.sel)
            3'd0: begin
                w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                e = !(s >= -2048 && s <= 2047);
            end
            3'd1: begin
                w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((u & 32'h1F) << 7) | op;
                e = !(s >= -2048 && s <= 2047);
            end
            3'd2: begin
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                    | (((u >> 11) & 1) << 7) | op;
                e = !(s >= -4096 && s <= 4095 && (u % 2) == 0);
            end
            3'd3: begin
                w = (u & 32'hFFFFF000) | (rd << 7) | op;
                e = (u % 4096) != 0;
            end
            3'd4: begin
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                    | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | op;
                e = !(s >= -1048576 && s <= 1048575 && (u % 2) == 0);
            end
            3'd5: begin
                if (s >= -2048 && s <= 2047) begin
                    w = ((u & 32'hFFF) << 20) | (rd << 7) | 32'h13;
                end else begin
                    hi = (u + 32'h800) >> 12;
                    exp_q.push_back('{inst: (hi << 12) | (rd << 7) | 32'h37, err: 1'b0,
                                      last: 1'b0});
                    w = ((u & 32'hFFF) << 20) | (rd << 15) | (rd << 7) | 32'h13;
                end
            end
            3'd6: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            default: begin
                w = 32'hDEADBEEF;
                e = 1'b1;
            end
        endcase
        exp_q.push_back('{inst: w, err: e, last: 1'b1});
    endtask

    task automatic drive(input logic v, input req_t r, input logic ordy);
        bus.in_valid = v; bus.in_sel = r.sel; bus.in_opcode = r.op; bus.in_rd = r.rd;
        bus.in_rs1 = r.rs1; bus.in_rs2 = r.rs2; bus.in_funct3 = r.f3; bus.in_funct7 = r.f7;
        bus.in_imm = r.imm; bus.out_ready = ordy;
    endtask

    // One clock: entered and left at posedge+1; checks the held beat and handshake.
    task automatic cycle(input logic v, input req_t r, input logic ordy, output logic acc);
        logic cons;
        drive(v, r, ordy);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        chk("in_ready", 32'(bus.in_ready),
            32'(exp_q.size() == 0 || (exp_q.size() == 1 && ordy)));
        if (exp_q.size() != 0) begin
            chk("beat inst", bus.out_inst, exp_q[0].inst);
            chk("beat err", 32'(bus.out_err), 32'(exp_q[0].err));
            chk("beat last", 32'(bus.out_last), 32'(exp_q[0].last));
        end
        acc  = v && bus.in_ready;
        cons = bus.out_valid && ordy;
        @(posedge clk);
        #1;
        if (cons && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            nbeats++;
        end
        if (acc) model(r);
    endtask

    task automatic send(input req_t r, input logic ordy);
        logic acc;
        int   n = 0;
        do begin
            cycle(1'b1, r, ordy, acc);
            n++;
        end while (!acc && n < 50);
        chk("request accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
            cycle(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, acc);
            n++;
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        rst = 1'b1;
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_inst", bus.out_inst, 32'd0);
        chk("rst out_err", 32'(bus.out_err), 32'd0);
        chk("rst out_last", 32'(bus.out_last), 32'd0);
        chk("rst beat_count", 32'(bus.beat_count), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        nbeats = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r = mk(int'($urandom_range(0, 7)), int'($urandom), int'($urandom), int'($urandom),
               int'($urandom), int'($urandom), int'($urandom), 0);
        case ($urandom_range(0, 3))
            0:       r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       r.imm = $urandom;
            2:       r.imm = $urandom & 32'hFFFFF000;
            default: r.imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        endcase
        if ($urandom_range(0, 1) == 1) r.imm[0] = 1'b0;
        return r;
    endfunction

    initial begin
        logic        acc;
        logic [31:0] held;
        int          accs;
        vec_t        v;

        rst = 1'b1;
        drive(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        #3;
        chk("init out_valid", 32'(bus.out_valid), 32'd0);
        chk("init out_inst", bus.out_inst, 32'd0);
        chk("init beat_count", 32'(bus.beat_count), 32'd0);
        chk("init in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        tbl.push_back('{mk(0, 'h13, 1, 2, 0, 0, 0, -1), 32'hFFF10093, 1'b0, 1'b1});
        tbl.push_back('{mk(0, 'h13, 1, 2, 0, 0, 0, 2048), 32'h80010093, 1'b1, 1'b1});
        tbl.push_back('{mk(2, 'h63, 0, 1, 2, 0, 0, -4), 32'hFE208EE3, 1'b0, 1'b1});
        tbl.push_back('{mk(2, 'h63, 0, 1, 2, 0, 0, 3), 32'h00208163, 1'b1, 1'b1});
        tbl.push_back('{mk(5, 0, 5, 0, 0, 0, 0, 'hFFFFF800), 32'h80000293, 1'b0, 1'b1});
        tbl.push_back('{mk(7, 0, 0, 0, 0, 0, 0, 0), 32'hDEADBEEF, 1'b1, 1'b1});
        tbl.push_back('{mk(6, 'h33, 3, 1, 2, 0, 'h20, 0), 32'h402081B3, 1'b0, 1'b1});
        tbl.push_back('{mk(3, 'h37, 5, 0, 0, 0, 0, 'h12345000), 32'h123452B7, 1'b0, 1'b1});
        tbl.push_back('{mk(3, 'h37, 5, 0, 0, 0, 0, 'h12345001), 32'h123452B7, 1'b1, 1'b1});
        tbl.push_back('{mk(1, 'h23, 0, 1, 2, 2, 0, -8), 32'hFE20AC23, 1'b0, 1'b1});
        tbl.push_back('{mk(4, 'h6F, 1, 0, 0, 0, 0, 2048), 32'h001000EF, 1'b0, 1'b1});

        foreach (tbl[i]) begin
            v = tbl[i];
            send(v.r, 1'b1);
            chk($sformatf("tbl%0d inst", i), bus.out_inst, v.inst);
            chk($sformatf("tbl%0d err", i), 32'(bus.out_err), 32'(v.err));
            chk($sformatf("tbl%0d last", i), 32'(bus.out_last), 32'(v.last));
            drain();
        end

        // Two-beat li: LUI then ADDI, input blocked in between.
        send(mk(5, 0, 5, 0, 0, 0, 0, 'h12345FFF), 1'b1);
        chk("li beat1 inst", bus.out_inst, 32'h123462B7);
        chk("li beat1 last", 32'(bus.out_last), 32'd0);
        chk("li in_ready low", 32'(bus.in_ready), 32'd0);
        cycle(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, acc);
        chk("li beat2 inst", bus.out_inst, 32'hFFF28293);
        chk("li beat2 last", 32'(bus.out_last), 32'd1);
        drain();

        // Eight back-to-back J requests from a fresh counter.
        do_reset();
        accs = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, mk(4, 'h6F, i + 1, 0, 0, 0, 0, 4 * i - 16), 1'b1, acc);
            if (acc) accs++;
        end
        chk("b2b accepts", 32'(accs), 32'd8);
        drain();
        chk("b2b beat_count", 32'(bus.beat_count), 32'd8);

        // Stall: held beat stays put and no new request slips in.
        send(mk(0, 'h13, 7, 3, 0, 1, 0, 100), 1'b0);
        held = bus.out_inst;
        for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
            cycle(1'b1, mk(6, 'h33, 1, 1, 1, 0, 0, 0), 1'b0, acc);
            chk("stall no accept", 32'(acc), 32'd0);
            chk("stall hold", bus.out_inst, held);
        end
        drain();

        // Reset while the LUI is held: ADDI is dropped.
        send(mk(5, 0, 9, 0, 0, 0, 0, 'h7FFFFFFF), 1'b0);
        chk("pre-rst li last", 32'(bus.out_last), 32'd0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, acc);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 2) != 0, rand_req(), $urandom_range(0, 3) != 0, acc);
        end
        drain();
        chk("rand beat_count", 32'(bus.beat_count), nbeats % 65536);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder for the RISC-V datapath: the inverse of the immediate generator. It accepts decoded instruction fields (format select, opcode, register indices, funct fields, a full 32-bit immediate) over a valid/ready handshake and emits packed 32-bit RV32I instruction words on a registered valid/ready output. It also range-checks immediates and expands the `li` pseudo-instruction into one or two beats. It feeds the instruction-memory loader and the self-test program generator.

## Interface
- `COUNT_W`, 16, width of the emitted-beat counter
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `in_sel`  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J (same codes as the immediate generator), 101 LI pseudo, 110 R, 111 illegal
- `in_opcode`  in  7  inst[6:0] (ignored for LI)
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices
- `in_funct3`  in  3; `in_funct7`  in  7
- `in_imm`  in  32  byte-offset immediate, two's complement
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  beat consumed when `out_valid && out_ready`
- `out_inst`  out  32  encoded word
- `out_err`  out  1  immediate out of range or illegal `in_sel`
- `out_last`  out  1  final beat of the current request
- `beat_count`  out  COUNT_W  number of beats consumed, wraps

## Operation
- Encoding (opcode in [6:0], rd in [11:7] where used):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; `out_err`=0
  - I: {imm[11:0], rs1, funct3, rd, opcode}; err unless imm[31:11] all equal
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; err unless imm[31:11] all equal
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; err unless imm[31:12] all equal and imm[0]=0
  - U: {imm[31:12], rd, opcode}; err unless imm[11:0]=0
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; err unless imm[31:20] all equal and imm[0]=0
  - 111: `out_inst`=32'hDEADBEEF, `out_err`=1
- On range error the word is still encoded from the truncated fields and emitted with `out_err`=1.
- LI (rd, imm), never `out_err`:
  - imm[31:11] all equal: one beat, ADDI rd,x0,imm = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011}, `out_last`=1
  - otherwise: hi = imm[31:12] + imm[11] (20-bit, wraps). Beat 1 is LUI {hi, rd, 7'b0110111} with `out_last`=0. Beat 2 is ADDI rd,rd,imm[11:0] = {imm[11:0], rd, 3'b000, rd, 7'b0010011} with `out_last`=1. The second-beat fields are captured at accept.
- FSM:
  - IDLE: no beat held
  - HOLD: last beat of a request held
  - LI_HI: LUI held, ADDI pending
- Transitions:
  - IDLE + accept -> HOLD, or LI_HI for a two-beat LI
  - HOLD + consume, no accept -> IDLE
  - HOLD + consume + accept -> HOLD or LI_HI (back-to-back)
  - LI_HI + consume -> HOLD with the ADDI beat loaded
- `in_ready` is combinational: 1 in IDLE; `out_ready` in HOLD; 0 in LI_HI.
- `beat_count` increments on each consumed beat and wraps from 2^COUNT_W-1 to 0.

## Timing
- Reset (async, immediate):
  - outputs: `out_valid`=0, `out_inst`=0, `out_err`=0, `out_last`=0, `beat_count`=0
  - state: IDLE, so `in_ready`=1
- Latency: a request accepted at edge N is presented at `out_valid` after edge N. The LI second beat appears the cycle after the LUI is consumed.
- Throughput: one beat per cycle with `out_ready` held high. A two-beat LI blocks input for one extra cycle.
- While `out_ready`=0, `out_inst`, `out_err` and `out_last` hold stable. `out_valid` never drops without a consume.
- Reset asserted mid-LI discards the pending ADDI. No beat is emitted after reset deasserts until a new accept.

## Test plan
- I-type, opcode 7'h13, rd=1, rs1=2, funct3=0, imm=-1 -> 32'hFFF10093, err=0, last=1. Same with imm=2048 -> err=1.
- B-type, opcode 7'h63, rs1=1, rs2=2, funct3=0, imm=-4 -> 32'hFE208EE3, err=0. imm=3 -> err=1.
- LI rd=5, imm=32'h12345FFF -> beat 1 32'h123462B7 (last=0), beat 2 32'hFFF28293 (last=1). `in_ready`=0 between the beats.
- LI rd=5, imm=32'hFFFFF800 -> single beat 32'h80000293 (last=1).
- Back-to-back: 8 J-type requests with `out_ready` high -> 8 beats in 8 consecutive cycles, `beat_count`=8. Then a random `out_ready` stall holds `out_inst` stable.
- Assert `rst` while in LI_HI -> `out_valid`=0 immediately, no ADDI after release; `in_sel`=111 -> 32'hDEADBEEF with err=1.
